// File: rtl/spiker_pkg.sv
// Shared definitions for the spiking-core result path.
// Holds the default result-frame geometry used by both the collector and the
// register-file result writer, and the collector FSM state type.
package spiker_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int N_REG_DEF  = 24;
    localparam int DATA_W_DEF = WIDTH_DEF * N_REG_DEF;

    typedef enum logic [1:0] {
        COLL_IDLE    = 2'd0,
        COLL_COLLECT = 2'd1,
        COLL_DRAIN   = 2'd2
    } collector_state_e;

endpackage : spiker_pkg

// File: rtl/spiker_result_collector.sv
// Spiking-core result collector.
// Assembles a frame of N_REG WIDTH-bit words from the core's valid/ready
// stream into a shadow buffer, then commits the whole vector to data_o in a
// single edge so the downstream result writer never sees a partial result.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   start_i     one-cycle pulse, arms (or restarts) collection of a frame
//   in_valid_i  core word valid
//   in_ready_o  collector ready (high in COLLECT and DRAIN)
//   in_data_i   core result word
//   in_last_i   final word of the core frame
//   data_o      committed result vector (word 0 in the LSBs)
//   done_o      one-cycle pulse after data_o receives a complete frame
//   busy_o      high in COLLECT or DRAIN
//   err_o       sticky frame-length error, cleared by start_i or reset
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; not ready, upstream words stay pending
// COLLECT | accepting words 0..N_REG-1 into the shadow buffer
// DRAIN | frame was too long; swallow words up to and including last
module spiker_result_collector
    import spiker_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int N_REG      = N_REG_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      in_data_i,
    input  logic                  in_last_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int CNT_W = $clog2(N_REG);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_REG - 1);

    if (DATA_WIDTH != WIDTH * N_REG) begin : g_bad_width
        $error("spiker_result_collector: DATA_WIDTH must equal WIDTH*N_REG");
    end

    collector_state_e      state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] shadow_wr;
    logic                  accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= COLL_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Ready depends only on state, never on the incoming word.
    assign in_ready_o = (state_q != COLL_IDLE);
    assign busy_o     = (state_q != COLL_IDLE);
    assign data_o     = data_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

    assign accept = in_valid_i && in_ready_o;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = err_q;

        // Shadow with the current word dropped into its slot; this is what
        // gets committed on the final word so that word lands in data_o too.
        shadow_wr = shadow_q;
        shadow_wr[cnt_q * WIDTH +: WIDTH] = in_data_i;

        if (start_i) begin
            // Restart wins over any word handshaked in the same cycle.
            state_d = COLL_COLLECT;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                COLL_COLLECT: begin
                    if (accept) begin
                        shadow_d = shadow_wr;
                        if (cnt_q == LAST_IDX) begin
                            data_d = shadow_wr;
                            done_d = 1'b1;
                            cnt_d  = '0;
                            if (in_last_i) begin
                                state_d = COLL_IDLE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = COLL_DRAIN;
                            end
                        end else if (in_last_i) begin
                            // Short frame: leave data_o holding the previous result.
                            err_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = COLL_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                COLL_DRAIN: begin
                    if (accept && in_last_i) begin
                        state_d = COLL_IDLE;
                    end
                end
                default: begin
                    state_d = COLL_IDLE;
                end
            endcase
        end
    end

endmodule : spiker_result_collector

// File: tb/tb_spiker_result_collector.sv
module tb_spiker_result_collector;

    localparam int W  = 32;
    localparam int NR = 24;
    localparam int DW = W * NR;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  in_data_i;
    logic          in_last_i;
    logic [DW-1:0] data_o;
    logic          done_o;
    logic          busy_o;
    logic          err_o;

    spiker_result_collector #(.WIDTH(W), .N_REG(NR), .DATA_WIDTH(DW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .in_last_i  (in_last_i),
        .data_o     (data_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    // Frame-level view: a queue of words accepted for the current frame,
    // whether the collector is listening at all, and whether it is only
    // swallowing the tail of an overlong frame.
    bit          m_listen;
    bit          m_swallow;
    int unsigned m_words[$];
    logic [DW-1:0] m_data;
    bit          m_done;
    bit          m_err;
    int          n_done_seen;
    int          n_accepted;
    bit          chk_en = 0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_listen = 0; m_swallow = 0; m_words.delete();
            m_data = '0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (start_i) begin
                m_words.delete();
                m_err = 0; m_listen = 1; m_swallow = 0;
            end else if (m_listen && in_valid_i) begin
                n_accepted++;
                if (m_swallow) begin
                    if (in_last_i) begin m_listen = 0; m_swallow = 0; end
                end else begin
                    m_words.push_back(in_data_i);
                    if (m_words.size() == NR) begin
                        for (int i = 0; i < NR; i++) m_data[i*W +: W] = m_words[i];
                        m_done = 1;
                        m_words.delete();
                        if (in_last_i) m_listen = 0;
                        else begin m_err = 1; m_swallow = 1; end
                    end else if (in_last_i) begin
                        m_err = 1; m_listen = 0; m_words.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("in_ready", {{(DW-1){1'b0}}, in_ready_o}, {{(DW-1){1'b0}}, m_listen});
            chk("busy",     {{(DW-1){1'b0}}, busy_o},     {{(DW-1){1'b0}}, m_listen});
            chk("done",     {{(DW-1){1'b0}}, done_o},     {{(DW-1){1'b0}}, m_done});
            chk("err",      {{(DW-1){1'b0}}, err_o},      {{(DW-1){1'b0}}, m_err});
            chk("data",     data_o, m_data);
            if (done_o === 1'b1) n_done_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Send n words base+k, last asserted on word last_at; gaps randomly
    // drop valid. Gives up on a word after a bounded number of cycles.
    task automatic send_frame(input int unsigned base, input int n, input int last_at, input bit gaps);
        bit rdy;
        int budget;
        for (int k = 0; k < n; k++) begin
            budget = 0;
            forever begin
                in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data_i  = base + k;
                in_last_i  = (k == last_at);
                @(negedge clk_i);
                rdy = in_ready_o;
                step();
                if (in_valid_i && rdy) break;
                budget++;
                if (budget > 200) begin
                    n_checks++;
                    $display("FAIL handshake_timeout: word %0d not accepted within %0d cycles", k, budget);
                    in_valid_i = 1'b0;
                    return;
                end
            end
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    int done_before;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
        step(); step();
        chk_en = 1;
        step();
        rst_i = 1'b0;
        chk("rst_data", data_o, '0);
        chk("rst_ready", {{(DW-1){1'b0}}, in_ready_o}, '0);

        // Nominal frame
        done_before = n_done_seen;
        pulse_start();
        send_frame(32'h1000_0000, 24, 23, 0);
        chk("nom_done_latency", {{(DW-1){1'b0}}, done_o}, {{(DW-1){1'b0}}, 1'b1});
        step(); step();
        chk("nom_word0",  {{(DW-W){1'b0}}, data_o[31:0]},    {{(DW-W){1'b0}}, 32'h1000_0000});
        chk("nom_word23", {{(DW-W){1'b0}}, data_o[767:736]}, {{(DW-W){1'b0}}, 32'h1000_0017});
        chk("nom_err",    {{(DW-1){1'b0}}, err_o}, '0);
        chk("nom_done_cnt", DW'(n_done_seen - done_before), DW'(1));

        // Word pending while IDLE, then gapped frame with identical content
        in_valid_i = 1'b1; in_data_i = 32'h1000_0000; in_last_i = 1'b0;
        step(); step(); step();
        chk("idle_not_ready", {{(DW-1){1'b0}}, in_ready_o}, '0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        send_frame(32'h1000_0000, 24, 23, 1);
        step(); step();
        chk("gap_word0",  {{(DW-W){1'b0}}, data_o[31:0]},    {{(DW-W){1'b0}}, 32'h1000_0000});
        chk("gap_word23", {{(DW-W){1'b0}}, data_o[767:736]}, {{(DW-W){1'b0}}, 32'h1000_0017});

        // Short frame: last on word 10
        done_before = n_done_seen;
        pulse_start();
        send_frame(32'h2000_0000, 11, 10, 0);
        step(); step();
        chk("short_err",  {{(DW-1){1'b0}}, err_o}, {{(DW-1){1'b0}}, 1'b1});
        chk("short_keep", {{(DW-W){1'b0}}, data_o[31:0]}, {{(DW-W){1'b0}}, 32'h1000_0000});
        chk("short_idle", {{(DW-1){1'b0}}, in_ready_o}, '0);
        chk("short_no_done", DW'(n_done_seen - done_before), '0);

        // Long frame: 30 words, last on the 30th
        done_before = n_done_seen;
        n_accepted = 0;
        pulse_start();
        chk("start_clears_err", {{(DW-1){1'b0}}, err_o}, '0);
        send_frame(32'h3000_0000, 30, 29, 0);
        step(); step();
        chk("long_word23", {{(DW-W){1'b0}}, data_o[767:736]}, {{(DW-W){1'b0}}, 32'h3000_0017});
        chk("long_err",    {{(DW-1){1'b0}}, err_o}, {{(DW-1){1'b0}}, 1'b1});
        chk("long_idle",   {{(DW-1){1'b0}}, in_ready_o}, '0);
        chk("long_consumed", DW'(n_accepted), DW'(30));
        chk("long_done_cnt", DW'(n_done_seen - done_before), DW'(1));

        // Abort: start coincides with word 6, then a full new frame
        pulse_start();
        send_frame(32'h4000_0000, 6, 99, 0);
        start_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hDEAD_BEEF; in_last_i = 1'b0;
        step();
        start_i = 1'b0; in_valid_i = 1'b0;
        done_before = n_done_seen;
        send_frame(32'h5000_0000, 24, 23, 0);
        step(); step();
        chk("abort_word0",  {{(DW-W){1'b0}}, data_o[31:0]},    {{(DW-W){1'b0}}, 32'h5000_0000});
        chk("abort_word23", {{(DW-W){1'b0}}, data_o[767:736]}, {{(DW-W){1'b0}}, 32'h5000_0017});
        chk("abort_err",    {{(DW-1){1'b0}}, err_o}, '0);
        chk("abort_done_cnt", DW'(n_done_seen - done_before), DW'(1));

        // Reset mid-frame after word 12
        pulse_start();
        send_frame(32'h6000_0000, 13, 99, 0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midrst_data",  data_o, '0);
        chk("midrst_ready", {{(DW-1){1'b0}}, in_ready_o}, '0);
        chk("midrst_busy",  {{(DW-1){1'b0}}, busy_o}, '0);
        pulse_start();
        send_frame(32'h7000_0000, 24, 23, 0);
        step(); step();
        chk("post_rst_word0",  {{(DW-W){1'b0}}, data_o[31:0]},    {{(DW-W){1'b0}}, 32'h7000_0000});
        chk("post_rst_word23", {{(DW-W){1'b0}}, data_o[767:736]}, {{(DW-W){1'b0}}, 32'h7000_0017});

        step();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spiker_result_collector
